palette_ctrl: RTL and testbench
===============================

# palette_ctrl

Programmable palette controller for the VGA video path. It holds a CPU-writable shadow palette of six 12-bit colors and an active palette. It copies shadow to active only at the start of vertical blanking, so a palette change never tears mid-frame. Each pixel is colored from the active palette using the world-map pixel and icon pixel codes. The result drives the VGA color pins through one register stage.

## Interface
Parameters:
- none; the palette size is fixed at 6 entries, 12 bits each ({R,G,B} 4 bits each).

Ports:
- clk  in  1  pixel clock; the only clock domain.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  shadow write request; the requester holds it until wr_ack.
- wr_idx  in  3  shadow entry index, 0..5.
- wr_color  in  12  color, {R[11:8],G[7:4],B[3:0]}.
- wr_ack  out  1  one-cycle pulse: the write was accepted.
- wr_err  out  1  one-cycle pulse with wr_ack when wr_idx > 5; no entry is written.
- commit_req  in  1  one-cycle pulse: apply the shadow palette at the next frame_end.
- frame_end  in  1  one-cycle pulse from the dtg at the start of vertical blanking.
- commit_busy  out  1  high while a commit is pending or copying.
- commit_done  out  1  one-cycle pulse when the copy completes.
- video_on  in  1  display enable from the dtg.
- world_pixel  in  2  world-map code: 0 background, 1 path, 2 obstruction, 3 reserved.
- icon  in  2  icon code; 0 means transparent.
- vgaRed, vgaGreen, vgaBlue  out  4 each  registered pixel color.

## Operation
- Entries: 0 BKGD, 1 PATH, 2 OBST, 3 ICON1, 4 ICON2, 5 ICON3.
- Reset values, for both shadow and active: 0x495, 0xFC6, 0xB20, 0x000, 0xD80, 0xFB9.
- Pixel lookup:
  - icon != 0 selects active[2+icon].
  - Otherwise world_pixel 0/1/2 selects active[0/1/2]; world_pixel 3 selects active[0].
  - video_on = 0 forces 0x000.
- Writes:
  - A write is accepted when wr_req = 1, state != COPY, and wr_ack was low in the previous cycle. This gives at most one write per 2 cycles.
  - On acceptance, shadow[wr_idx] is updated in the same clock edge that raises wr_ack.
  - An index > 5 is acked with wr_err = 1 and changes nothing.
- FSM states:
  - IDLE: commit_req -> ARMED. frame_end is ignored.
  - ARMED: frame_end -> COPY with copy counter k = 0. commit_req is ignored (already pending).
  - COPY: active[k] <= shadow[k] each cycle, k = 0..5. After k = 5 the FSM goes to IDLE, or to ARMED if commit_req arrived during COPY (rearm flag). commit_done pulses on that exit transition.
- commit_req and frame_end in the same IDLE cycle: go to ARMED only. The copy happens at the following frame_end.
- commit_busy = (state != IDLE).
- Writes accepted in ARMED land in the shadow palette and are included in the pending commit.
- A write request during COPY stalls (no ack) until COPY ends.
- Reset mid-COPY:
  - Both palettes return to their reset values and the state returns to IDLE.
  - The rearm flag is cleared and the partial copy is discarded.

## Timing
- Reset values: wr_ack, wr_err, commit_busy, commit_done = 0; vgaRed/Green/Blue = 0.
- Pixel path latency is 1 cycle: inputs sampled at edge n appear on the VGA outputs after edge n.
- wr_ack/wr_err are high in the cycle after wr_req is sampled (registered).
  - The requester must drop wr_req in the cycle it sees wr_ack, or a second write is taken two cycles later.
- frame_end sampled in ARMED at edge n:
  - state = COPY after edge n.
  - active[0..5] are updated at edges n+1..n+6.
  - commit_done = 1 and commit_busy = 0 (unless rearmed) after edge n+6.
- The copy takes 6 cycles. It completes well inside vertical blanking; the block does not check video_on during COPY.

## Test plan
- Reset, then video_on = 1, icon = 0, world_pixel = 1 -> output {F,C,6} one cycle later. video_on = 0 -> {0,0,0}.
- Write idx 1 = 0x123 with no commit -> output for world_pixel 1 stays 0xFC6 across frame_end.
  - Then commit_req, then frame_end -> after 6+1 cycles world_pixel 1 gives 0x123 and commit_done pulses once.
- wr_req with idx 7 -> wr_ack = 1 and wr_err = 1 in the next cycle; all 6 shadow entries remain unchanged after the next commit.
- wr_req held high during COPY -> no wr_ack until the cycle after commit_done. The stalled write (idx 4 = 0xABC) is not in active until the next commit.
- commit_req during COPY -> commit_busy drops for no cycle and the state returns to ARMED. The next frame_end copies again, and commit_done pulses twice in total.
- Assert reset in the 3rd COPY cycle after writing idx 0 = 0x111 -> world_pixel 0 gives 0x495, commit_busy = 0, and no commit_done.

Source files
------------

// File: rtl/palette_ctrl_if.sv
// CPU-side bus of the palette controller: the shadow-write handshake and the commit control.
interface palette_ctrl_if;
  logic        wr_req;
  logic [2:0]  wr_idx;
  logic [11:0] wr_color;
  logic        wr_ack;
  logic        wr_err;
  logic        commit_req;
  logic        commit_busy;
  logic        commit_done;

  modport master (
    output wr_req, wr_idx, wr_color, commit_req,
    input  wr_ack, wr_err, commit_busy, commit_done
  );

  modport slave (
    input  wr_req, wr_idx, wr_color, commit_req,
    output wr_ack, wr_err, commit_busy, commit_done
  );
endinterface

// File: rtl/palette_ctrl.sv
// Shadow/active six-entry palette. Shadow is copied to active only at frame_end after a
// commit request, so the visible palette never changes mid-frame.
module palette_ctrl (
  input  logic        clk,
  input  logic        reset,
  palette_ctrl_if.slave bus,
  input  logic        frame_end,
  input  logic        video_on,
  input  logic [1:0]  world_pixel,
  input  logic [1:0]  icon,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  localparam int NUM_ENTRIES = 6;

  typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  k_reg, k_next;
  logic        rearm_reg, rearm_next;
  logic        done_reg, done_next;
  logic        ack_reg, err_reg;
  logic [11:0] pix_reg, pix_next;
  logic [2:0]  sel;
  logic        wr_accept;
  logic [NUM_ENTRIES*12-1:0] active_vec;

  function automatic logic [11:0] reset_color(input int idx);
    case (idx)
      0:       reset_color = 12'h495;
      1:       reset_color = 12'hFC6;
      2:       reset_color = 12'hB20;
      4:       reset_color = 12'hD80;
      5:       reset_color = 12'hFB9;
      default: reset_color = 12'h000;
    endcase
  endfunction

  // The previous-cycle ack blocks back-to-back acceptance while the requester drops wr_req.
  assign wr_accept = bus.wr_req && (state_reg != COPY) && !ack_reg;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    rearm_next = rearm_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.commit_req) state_next = ARMED;
      end
      ARMED: begin
        if (frame_end) begin
          state_next = COPY;
          k_next     = 3'd0;
        end
      end
      COPY: begin
        if (bus.commit_req) rearm_next = 1'b1;
        if (k_reg == 3'd5) begin
          state_next = (rearm_reg || bus.commit_req) ? ARMED : IDLE;
          rearm_next = 1'b0;
          done_next  = 1'b1;
          k_next     = 3'd0;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= 3'd0;
      rearm_reg <= 1'b0;
      done_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      pix_reg   <= 12'h000;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      rearm_reg <= rearm_next;
      done_reg  <= done_next;
      ack_reg   <= wr_accept;
      err_reg   <= wr_accept && (bus.wr_idx > 3'd5);
      pix_reg   <= pix_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic [11:0] shadow_reg;
      logic [11:0] active_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_reg <= reset_color(gi);
          active_reg <= reset_color(gi);
        end else begin
          if (wr_accept && (bus.wr_idx == 3'(gi))) shadow_reg <= bus.wr_color;
          if ((state_reg == COPY) && (k_reg == 3'(gi))) active_reg <= shadow_reg;
        end
      end

      assign active_vec[gi*12 +: 12] = active_reg;
    end
  endgenerate

  // Icons overlay the map; the reserved map code falls back to background.
  always_comb begin
    sel = 3'd0;
    if (icon != 2'd0) begin
      sel = 3'd2 + {1'b0, icon};
    end else if (world_pixel != 2'd3) begin
      sel = {1'b0, world_pixel};
    end
    pix_next = video_on ? active_vec[int'(sel)*12 +: 12] : 12'h000;
  end

  assign vgaRed          = pix_reg[11:8];
  assign vgaGreen        = pix_reg[7:4];
  assign vgaBlue         = pix_reg[3:0];
  assign bus.wr_ack      = ack_reg;
  assign bus.wr_err      = err_reg;
  assign bus.commit_busy = (state_reg != IDLE);
  assign bus.commit_done = done_reg;

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl: a reference palette model feeds a queue of expected
// pixels that is drained as the registered VGA outputs appear.
module tb_palette_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_end;
  logic       video_on;
  logic [1:0] world_pixel;
  logic [1:0] icon;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;

  palette_ctrl_if bus ();

  palette_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_end   (frame_end),
    .video_on    (video_on),
    .world_pixel (world_pixel),
    .icon        (icon),
    .vgaRed      (vgaRed),
    .vgaGreen    (vgaGreen),
    .vgaBlue     (vgaBlue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  logic [11:0] shadow_m [6];
  logic [11:0] active_m [6];
  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    logic [11:0] rv [6];
    rv = '{12'h495, 12'hFC6, 12'hB20, 12'h000, 12'hD80, 12'hFB9};
    for (int i = 0; i < 6; i++) begin
      shadow_m[i] = rv[i];
      active_m[i] = rv[i];
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic vo, input logic [1:0] wp, input logic [1:0] ic);
    if (!vo) return 12'h000;
    if (ic != 2'd0) return active_m[2 + int'(ic)];
    if (wp == 2'd3) return active_m[0];
    return active_m[int'(wp)];
  endfunction

  task automatic pix(input logic vo, input logic [1:0] wp, input logic [1:0] ic, input string tag);
    logic [11:0] got, e;
    video_on    = vo;
    world_pixel = wp;
    icon        = ic;
    exp_q.push_back(exp_pix(vo, wp, ic));
    step();
    got = {vgaRed, vgaGreen, vgaBlue};
    e   = exp_q.pop_front();
    $display("pixel %s vo=%0d wp=%0d icon=%0d -> %03h", tag, vo, wp, ic, got);
    check(tag, 32'(got), 32'(e));
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [11:0] color, input logic exp_err);
    bus.wr_req   = 1'b1;
    bus.wr_idx   = idx;
    bus.wr_color = color;
    step();
    $display("write idx=%0d color=%03h ack=%0d err=%0d", idx, color, bus.wr_ack, bus.wr_err);
    check("wr_ack", 32'(bus.wr_ack), 32'd1);
    check("wr_err", 32'(bus.wr_err), 32'(exp_err));
    bus.wr_req = 1'b0;
    if (idx <= 3'd5) shadow_m[idx] = color;
    step();
    check("wr_ack_pulse", 32'(bus.wr_ack), 32'd0);
  endtask

  // Runs commit_req then frame_end; leaves the bench in the first COPY cycle.
  task automatic start_commit();
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    check("busy_armed", 32'(bus.commit_busy), 32'd1);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic wait_done(input int rearm_at, output int cyc);
    cyc = 0;
    while (cyc < 10 && !bus.commit_done) begin
      check("busy_copy", 32'(bus.commit_busy), 32'd1);
      bus.commit_req = (cyc == rearm_at);
      step();
      bus.commit_req = 1'b0;
      cyc++;
      check("no_ack_copy", 32'(bus.wr_ack), 32'd0);
    end
    if (bus.commit_done) dones++;
    $display("commit done after %0d cycles", cyc);
    check("copy_cycles", 32'(cyc), 32'd6);
    for (int i = 0; i < 6; i++) active_m[i] = shadow_m[i];
  endtask

  int cyc;

  initial begin
    reset          = 1'b1;
    frame_end      = 1'b0;
    video_on       = 1'b0;
    world_pixel    = 2'd0;
    icon           = 2'd0;
    bus.wr_req     = 1'b0;
    bus.wr_idx     = 3'd0;
    bus.wr_color   = 12'h000;
    bus.commit_req = 1'b0;
    reset_model();
    repeat (3) step();
    reset = 1'b0;
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check("rst_busy", 32'(bus.commit_busy), 32'd0);
    check("rst_done", 32'(bus.commit_done), 32'd0);
    check("rst_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);

    // Lookup across all codes with reset palette.
    pix(1'b1, 2'd1, 2'd0, "path");
    pix(1'b0, 2'd1, 2'd0, "blank");
    pix(1'b1, 2'd0, 2'd0, "bkgd");
    pix(1'b1, 2'd2, 2'd0, "obst");
    pix(1'b1, 2'd3, 2'd0, "reserved");
    pix(1'b1, 2'd2, 2'd1, "icon1");
    pix(1'b1, 2'd0, 2'd2, "icon2");
    pix(1'b1, 2'd3, 2'd3, "icon3");
    pix(1'b0, 2'd0, 2'd3, "icon_blank");

    // Shadow write without commit is invisible, even across frame_end.
    do_write(3'd1, 12'h123, 1'b0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("busy_no_commit", 32'(bus.commit_busy), 32'd0);
    step();
    pix(1'b1, 2'd1, 2'd0, "path_uncommitted");
    start_commit();
    wait_done(-1, cyc);
    check("busy_after", 32'(bus.commit_busy), 32'd0);
    step();
    check("done_pulse", 32'(bus.commit_done), 32'd0);
    pix(1'b1, 2'd1, 2'd0, "path_committed");

    // Out-of-range index is acked with error and writes nothing.
    do_write(3'd7, 12'hFFF, 1'b1);
    start_commit();
    wait_done(-1, cyc);
    step();
    pix(1'b1, 2'd0, 2'd0, "e0");
    pix(1'b1, 2'd1, 2'd0, "e1");
    pix(1'b1, 2'd2, 2'd0, "e2");
    pix(1'b1, 2'd0, 2'd1, "e3");
    pix(1'b1, 2'd0, 2'd2, "e4");
    pix(1'b1, 2'd0, 2'd3, "e5");

    // Write held during COPY stalls until the cycle after commit_done.
    start_commit();
    bus.wr_req   = 1'b1;
    bus.wr_idx   = 3'd4;
    bus.wr_color = 12'hABC;
    wait_done(-1, cyc);
    step();
    $display("stalled write ack=%0d", bus.wr_ack);
    check("stall_ack", 32'(bus.wr_ack), 32'd1);
    bus.wr_req  = 1'b0;
    shadow_m[4] = 12'hABC;
    step();
    pix(1'b1, 2'd0, 2'd2, "icon2_old");
    start_commit();
    wait_done(-1, cyc);
    step();
    pix(1'b1, 2'd0, 2'd2, "icon2_new");

    // commit_req during COPY re-arms without a busy gap.
    dones = 0;
    do_write(3'd2, 12'h0F0, 1'b0);
    start_commit();
    wait_done(2, cyc);
    check("rearm_busy", 32'(bus.commit_busy), 32'd1);
    do_write(3'd2, 12'h00F, 1'b0);
    check("rearm_busy2", 32'(bus.commit_busy), 32'd1);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    wait_done(-1, cyc);
    check("rearm_idle", 32'(bus.commit_busy), 32'd0);
    check("rearm_dones", 32'(dones), 32'd2);
    step();
    pix(1'b1, 2'd2, 2'd0, "obst_rearm");

    // Reset in the third COPY cycle discards the partial copy.
    do_write(3'd0, 12'h111, 1'b0);
    start_commit();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_model();
    check("midrst_busy", 32'(bus.commit_busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.commit_done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_busy_late", 32'(bus.commit_busy), 32'd0);
    pix(1'b1, 2'd0, 2'd0, "bkgd_after_rst");
    pix(1'b1, 2'd2, 2'd0, "obst_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
